// File: rtl/rstseq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding
// and the counter terminal-count compare used by the sequencer and pulse stretchers.
package rstseq_pkg;

    typedef enum logic [1:0] {
        RST_HOLD  = 2'd0,
        WAIT_LOCK = 2'd1,
        GREL      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int NDOM = 4;

    function automatic logic cnt_tc(input logic [31:0] cnt, input logic [31:0] tc);
        return cnt == tc;
    endfunction

endpackage

// File: rtl/rstseq_pls.sv
// Single-domain soft-reset pulse stretcher: a request while enabled produces a
// PULSE_CYC-cycle pulse; a new request restarts it at full length.
module rstseq_pls
    import rstseq_pkg::*;
#(
    parameter int CW        = 8,
    parameter int PULSE_CYC = 4
) (
    input  logic clk,
    input  logic rst_,
    input  logic en,
    input  logic clr,
    input  logic req,
    output logic pls
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt <= '0;
            pls <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            pls <= 1'b0;
        end else if (en && req) begin
            cnt <= '0;
            pls <= 1'b1;
        end else if (pls) begin
            if (cnt_tc(32'(cnt), 32'(PULSE_CYC - 1))) begin
                cnt <= '0;
                pls <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rstseq04.sv
// Reset sequencer: holds global reset after any cause, waits for PLL lock, then
// releases four domains in a staggered order and services per-domain soft-reset pulses.
module rstseq04
    import rstseq_pkg::*;
#(
    parameter int HOLD_CYC  = 16,
    parameter int STEP_CYC  = 8,
    parameter int PULSE_CYC = 4,
    parameter int CW        = 8
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       locked,
    input  logic       swrst_req,
    input  logic [3:0] dmrst_req,
    output logic       grst_,
    output logic [3:0] rstmsk,
    output logic       ready
);

    // state | meaning
    // RST_HOLD  | global reset asserted, counting hold cycles
    // WAIT_LOCK | global reset asserted, waiting for PLL lock
    // GREL      | global reset released, domains released one per step
    // RUN       | all domains out of reset, soft-reset pulses serviced

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [3:0]    msk, msk_nxt;
    logic [3:0]    pls;
    logic          cause;
    logic          run_st;

    assign run_st = (state == RUN);
    assign cause  = swrst_req || (!locked && (state == GREL || state == RUN));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        msk_nxt   = msk;
        if (cause) begin
            state_nxt = RST_HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            msk_nxt   = 4'hF;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (cnt_tc(32'(cnt), 32'(HOLD_CYC))) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked) begin
                        state_nxt = GREL;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end
                end
                GREL: begin
                    if (cnt_tc(32'(cnt), 32'(STEP_CYC - 1))) begin
                        cnt_nxt      = '0;
                        msk_nxt[idx] = 1'b0;
                        idx_nxt      = idx + 1'b1;
                        if (idx == 2'd3) state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: ;
                default: begin
                    state_nxt = RST_HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    msk_nxt   = 4'hF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= RST_HOLD;
            cnt   <= '0;
            idx   <= '0;
            msk   <= 4'hF;
            grst_ <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            msk   <= msk_nxt;
            grst_ <= (state_nxt == GREL) || (state_nxt == RUN);
            ready <= (state_nxt == RUN);
        end
    end

    for (genvar i = 0; i < NDOM; i++) begin : g_pls
        rstseq_pls #(
            .CW       (CW),
            .PULSE_CYC(PULSE_CYC)
        ) u_pls (
            .clk (clk),
            .rst_(rst_),
            .en  (run_st),
            .clr (cause),
            .req (dmrst_req[i]),
            .pls (pls[i])
        );
    end

    // Sequencer mask and run-time pulses combine per domain.
    assign rstmsk = msk | pls;

endmodule

// File: tb/tb_rstseq04.sv
// Bench for rstseq04: directed timeline checks plus randomized traffic, all
// compared against a cycle-level model built from elapsed-time arithmetic.
module tb_rstseq04;

    localparam int HOLD_CYC  = 16;
    localparam int STEP_CYC  = 8;
    localparam int PULSE_CYC = 4;
    localparam int CW        = 8;

    logic       clk = 1'b0;
    logic       rst_;
    logic       locked;
    logic       swrst_req;
    logic [3:0] dmrst_req;
    logic       grst_;
    logic [3:0] rstmsk;
    logic       ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: hold edges counted since last cause, edges since global release (-1: not released),
    // remaining pulse cycles per domain.
    int m_hold;
    int m_age;
    int m_pls [4];

    always #5 clk = ~clk;

    rstseq04 #(
        .HOLD_CYC (HOLD_CYC),
        .STEP_CYC (STEP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .CW       (CW)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .locked   (locked),
        .swrst_req(swrst_req),
        .dmrst_req(dmrst_req),
        .grst_    (grst_),
        .rstmsk   (rstmsk),
        .ready    (ready)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hold = 0;
        m_age  = -1;
        for (int i = 0; i < 4; i++) m_pls[i] = 0;
    endtask

    task automatic model_edge();
        bit running;
        bit in_run;
        if (!rst_) begin
            model_clear();
            return;
        end
        running = (m_age >= 0);
        in_run  = (m_age >= 4 * STEP_CYC);
        if (swrst_req || (!locked && running)) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (in_run && dmrst_req[i]) m_pls[i] = PULSE_CYC;
                else if (m_pls[i] > 0) m_pls[i]--;
            end
            if (running) begin
                if (m_age < 4 * STEP_CYC) m_age++;
            end else if (m_hold >= HOLD_CYC + 1 && locked) begin
                m_age = 0;
            end else if (m_hold < HOLD_CYC + 1) begin
                m_hold++;
            end
        end
    endtask

    function automatic logic [3:0] exp_msk();
        logic [3:0] m;
        for (int i = 0; i < 4; i++)
            m[i] = (m_age < 0) || (i >= m_age / STEP_CYC) || (m_pls[i] > 0);
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("grst_", 8'(grst_), 8'(m_age >= 0));
        chk("rstmsk", 8'(rstmsk), 8'(exp_msk()));
        chk("ready", 8'(ready), 8'(m_age >= 4 * STEP_CYC));
    endtask

    // Asserts rst_ mid-cycle, checks outputs before any edge, holds 2 cycles, releases at a negedge.
    task automatic async_rst();
        #2 rst_ = 1'b0;
        #1;
        chk("async_grst_", 8'(grst_), 8'h00);
        chk("async_rstmsk", 8'(rstmsk), 8'h0F);
        chk("async_ready", 8'(ready), 8'h00);
        model_clear();
        @(negedge clk);
        step();
        step();
        rst_ = 1'b1;
    endtask

    initial begin
        rst_      = 1'b1;
        locked    = 1'b1;
        swrst_req = 1'b0;
        dmrst_req = 4'h0;
        model_clear();
        #1 rst_ = 1'b0;
        #1;
        chk("por_grst_", 8'(grst_), 8'h00);
        chk("por_rstmsk", 8'(rstmsk), 8'h0F);
        chk("por_ready", 8'(ready), 8'h00);
        @(negedge clk);
        for (int e = 0; e < 3; e++) step();
        rst_ = 1'b1;

        // Power-on timeline
        for (int e = 1; e <= 52; e++) begin
            step();
            if (e == 17) chk("po_grst_e17", 8'(grst_), 8'h00);
            if (e == 18) chk("po_grst_e18", 8'(grst_), 8'h01);
            if (e == 25) chk("po_msk_e25", 8'(rstmsk), 8'h0F);
            if (e == 26) chk("po_msk_e26", 8'(rstmsk), 8'h0E);
            if (e == 34) chk("po_msk_e34", 8'(rstmsk), 8'h0C);
            if (e == 42) chk("po_msk_e42", 8'(rstmsk), 8'h08);
            if (e == 49) chk("po_ready_e49", 8'(ready), 8'h00);
            if (e == 50) chk("po_msk_e50", 8'(rstmsk), 8'h00);
            if (e == 50) chk("po_ready_e50", 8'(ready), 8'h01);
        end

        // Domain pulse with re-request on bit 0
        dmrst_req = 4'b0101; step(); chk("pls_n1", 8'(rstmsk), 8'h05);
        dmrst_req = 4'b0000; step();
        dmrst_req = 4'b0001; step(); chk("pls_n3", 8'(rstmsk), 8'h05);
        dmrst_req = 4'b0000; step(); chk("pls_n4", 8'(rstmsk), 8'h05);
        step(); chk("pls_n5", 8'(rstmsk), 8'h01);
        chk("pls_ready", 8'(ready), 8'h01);
        step(); chk("pls_n6", 8'(rstmsk), 8'h01);
        step(); chk("pls_n7", 8'(rstmsk), 8'h00);

        // Late lock
        locked = 1'b0;
        #2 rst_ = 1'b0;
        model_clear();
        @(negedge clk);
        step();
        rst_ = 1'b1;
        for (int e = 1; e <= 40; e++) step();
        chk("ll_grst_e40", 8'(grst_), 8'h00);
        locked = 1'b1;
        for (int e = 41; e <= 80; e++) begin
            step();
            if (e == 41) chk("ll_grst_e41", 8'(grst_), 8'h01);
            if (e == 48) chk("ll_msk_e48", 8'(rstmsk), 8'h0F);
            if (e == 49) chk("ll_msk_e49", 8'(rstmsk), 8'h0E);
        end

        // Software reset for 5 cycles in RUN, then full replay
        swrst_req = 1'b1;
        step();
        chk("sw_grst_", 8'(grst_), 8'h00);
        chk("sw_rstmsk", 8'(rstmsk), 8'h0F);
        chk("sw_ready", 8'(ready), 8'h00);
        for (int e = 0; e < 4; e++) step();
        swrst_req = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            step();
            if (e == 17) chk("sw_grst_e17", 8'(grst_), 8'h00);
            if (e == 18) chk("sw_grst_e18", 8'(grst_), 8'h01);
            if (e == 50) chk("sw_ready_e50", 8'(ready), 8'h01);
        end

        // Lock loss during GREL after domain 1 released
        async_rst();
        for (int e = 0; e < 100 && rstmsk != 4'hC; e++) step();
        chk("lk_reach_C", 8'(rstmsk), 8'h0C);
        locked = 1'b0;
        step();
        chk("lk_rstmsk", 8'(rstmsk), 8'h0F);
        chk("lk_grst_", 8'(grst_), 8'h00);
        locked = 1'b1;
        for (int e = 0; e < 5; e++) step();
        chk("lk_hold_grst_", 8'(grst_), 8'h00);

        // Asynchronous reset during an active pulse
        for (int e = 0; e < 100 && !ready; e++) step();
        chk("ap_reach_run", 8'(ready), 8'h01);
        dmrst_req = 4'b0010; step();
        dmrst_req = 4'b0000; step();
        chk("ap_pls_on", 8'(rstmsk), 8'h02);
        async_rst();
        for (int e = 0; e < 10; e++) step();
        chk("ap_no_resume", 8'(rstmsk), 8'h0F);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (locked) locked = ($urandom_range(0, 299) != 0);
            else        locked = ($urandom_range(0, 9) == 0);
            if (swrst_req) swrst_req = ($urandom_range(0, 2) != 0);
            else           swrst_req = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < 4; i++) dmrst_req[i] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1499) == 0) async_rst();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
